fc_result_argmax: RTL
=====================

Name: fc_result_argmax

Overview:
- Final classification stage, directly downstream of the VGG16 fully-connected result port.
- Walks the FC3 output buffer word by word over the result read interface (address, valid, ready).
- Computes a top-1 class index and score for each of the BATCH images in parallel.
- Returns the results to the host/test harness through a single valid/ready output beat.

Parameters:
AF, 3, lanes (classes) per result word
BATCH, 9, images processed in parallel
FOUT3, 1000, number of classes
DATA_WIDTH, 8, signed fixed-point score width (4 fractional bits; ordering is unaffected by the fraction)
ADDR_WIDTH, 32, result read address width
IDX_W, $clog2(FOUT3) = 10, class index width
NUM_WORDS, ceil(FOUT3/AF) = 334, result words to read

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
start  in  1  single-cycle scan request; honoured only in IDLE
busy  out  1  high from the cycle after start is accepted until the output handshake completes
rd_addr  out  ADDR_WIDTH  result word address (0..NUM_WORDS-1); drives result_rd_ADDR
rd_ready  out  1  drives result_ready
rd_valid  in  1  from result_valid
rd_data  in  [BATCH] x [AF][DATA_WIDTH]  from result_data; lane a of word w is class w*AF+a
top_idx  out  [BATCH] x IDX_W  argmax class per image
top_score  out  [BATCH] x DATA_WIDTH  score of that class
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result

Behaviour:
- Reset values: every output is 0, state is IDLE, and all running registers are cleared. A reset in any state aborts the scan at once; no partial result is ever presented.
- FSM states: IDLE, SCAN, FLUSH, HOLD.
- IDLE:
  - start moves to SCAN; rd_addr is 0 and the running-valid flag is cleared.
  - start in any other state is ignored.
- SCAN:
  - rd_ready = 1 and rd_addr holds the current word index.
  - A beat is accepted when rd_valid && rd_ready. rd_data must match the rd_addr presented in that same cycle.
  - On acceptance, rd_addr increments.
  - On acceptance of word NUM_WORDS-1, rd_ready drops the next cycle and the FSM moves to FLUSH.
  - rd_valid low stalls the scan with no state change. rd_addr stays stable while no beat is accepted.
- Pipeline stage 1 (registered on acceptance):
  - Per batch, select the maximum of the AF lanes with a signed compare.
  - Lanes whose class is >= FOUT3 are masked and never win. In the last word, lanes 1..2 are masked when FOUT3=1000.
  - Register the lane value, its class index (w*AF + lane) and a stage valid bit.
- Pipeline stage 2:
  - If the running-valid flag is clear, load the stage-1 value and index and set the flag.
  - Otherwise replace the running value and index only when the candidate is strictly greater.
  - Ties keep the lower class index. This holds both within a word (lowest lane wins) and across words.
- FLUSH:
  - Waits for both pipeline stages to drain, which takes 2 cycles after the last acceptance.
  - Then moves to HOLD, copies the running registers to top_idx/top_score and asserts out_valid.
- Latency: out_valid rises exactly 2 cycles after the clock edge that accepts word NUM_WORDS-1.
- HOLD:
  - out_valid and the output values stay stable until out_ready.
  - On out_valid && out_ready, the next state is IDLE, out_valid drops and busy drops. top_idx/top_score keep their values until the next scan completes.
  - A start arriving in the same cycle as the output handshake is ignored.
- Arithmetic: all compares are two's-complement signed DATA_WIDTH. -128 is a legal score. Index arithmetic is unsigned, IDX_W wide.
- rd_addr never exceeds NUM_WORDS-1; no wrap-around occurs.

Decomposition:
- The shared parameter package holds:
  - typedef score_t (logic signed [DATA_WIDTH-1:0]);
  - typedef cls_idx_t (logic [IDX_W-1:0]);
  - constant NUM_WORDS;
  - the FSM state enum argmax_state_e.
- One sub-module, argmax_lane_reduce: a combinational AF-lane signed max with lane mask and lowest-index tie-break. It is instantiated BATCH times ahead of the stage-1 register.

Test Plan:
1. Reset, then start. Batch b is set so class 100*b+5 = 0x70 and every other class = 0x10, with rd_valid held high. Expected: top_idx[b] = 100*b+5 and top_score = 0x70; out_valid rises 2 cycles after the address-333 beat.
2. All scores = 0x80 (-128). Expected: top_idx = 0 and top_score = 0x80 for every batch. A negative-only range such as -3 at class 999 versus -5 elsewhere returns 999.
3. Ties: class 4 and class 700 both 0x50, all else 0x00. Expected: top_idx = 4. Within one word, lanes 1 and 2 equal → lower class wins.
4. Masking: address 333, lanes 1..2 = 0x7F (padding), real maximum 0x40 at class 12. Expected: top_idx = 12; the padding is ignored.
5. Backpressure: rd_valid toggled randomly and out_ready held low for 20 cycles. Expected: rd_addr stays stable while no beat is accepted, no word is skipped or duplicated, and the outputs stay stable until out_ready.
6. Reset asserted during SCAN at address 150. Expected: all outputs are 0 and the FSM is in IDLE. A fresh start yields the correct result; start pulses issued during SCAN or HOLD are ignored.

Source files
------------

// File: rtl/fc_result_argmax_pkg.sv
// Shared parameters, types and FSM state encoding for the FC3 top-1 argmax stage.
package fc_result_argmax_pkg;

    localparam int AF         = 3;
    localparam int BATCH      = 9;
    localparam int FOUT3      = 1000;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int IDX_W      = $clog2(FOUT3);
    localparam int NUM_WORDS  = (FOUT3 + AF - 1) / AF;
    localparam int WORD_W     = $clog2(NUM_WORDS);
    localparam int LANE_W     = (AF > 1) ? $clog2(AF) : 1;

    typedef logic signed [DATA_WIDTH-1:0] score_t;
    typedef logic [IDX_W-1:0]             cls_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        HOLD
    } argmax_state_e;

endpackage

// File: rtl/fc_result_argmax_lane_reduce.sv
// Combinational signed max over the AF lanes of one result word.
// Masked lanes never win; on equal values the lowest lane is kept.
module argmax_lane_reduce
    import fc_result_argmax_pkg::*;
(
    input  logic [AF*DATA_WIDTH-1:0] lanes,
    input  logic [AF-1:0]            lane_mask,
    output logic [DATA_WIDTH-1:0]    max_val,
    output logic [LANE_W-1:0]        max_lane
);

    score_t best;
    score_t cand;
    logic   found;

    always_comb begin
        best     = '0;
        cand     = '0;
        found    = 1'b0;
        max_lane = '0;
        for (int a = 0; a < AF; a++) begin
            cand = score_t'(lanes[a*DATA_WIDTH +: DATA_WIDTH]);
            // strict compare keeps the earlier (lower-class) lane on ties
            if (lane_mask[a] && (!found || cand > best)) begin
                best     = cand;
                max_lane = LANE_W'(a);
                found    = 1'b1;
            end
        end
        max_val = best;
    end

endmodule

// File: rtl/fc_result_argmax.sv
// Scans the FC3 result buffer word by word and returns the top-1 class index
// and score per batch image through a single valid/ready beat.
module fc_result_argmax
    import fc_result_argmax_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic                             rd_ready,
    input  logic                             rd_valid,
    input  logic [BATCH*AF*DATA_WIDTH-1:0]   rd_data,
    output logic [BATCH*IDX_W-1:0]           top_idx,
    output logic [BATCH*DATA_WIDTH-1:0]      top_score,
    output logic                             out_valid,
    input  logic                             out_ready
);

    argmax_state_e         state_reg, state_next;
    logic [WORD_W-1:0]     word_reg;
    logic                  flush_cnt_reg;
    logic                  accept;
    logic                  load_out;
    logic                  last_word;
    logic [IDX_W:0]        word_base;
    logic [AF-1:0]         lane_mask;

    score_t                red_val   [BATCH];
    logic [LANE_W-1:0]     red_lane  [BATCH];
    logic                  s1_valid_reg;
    score_t                s1_val_reg  [BATCH];
    cls_idx_t              s1_idx_reg  [BATCH];
    logic                  run_valid_reg;
    score_t                run_val_reg [BATCH];
    cls_idx_t              run_idx_reg [BATCH];
    score_t                top_score_reg [BATCH];
    cls_idx_t              top_idx_reg   [BATCH];

    assign last_word = (word_reg == WORD_W'(NUM_WORDS - 1));
    assign word_base = (IDX_W+1)'(word_reg) * (IDX_W+1)'(AF);
    assign rd_addr   = ADDR_WIDTH'(word_reg);
    assign rd_ready  = (state_reg == SCAN);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == HOLD);

    // Padding lanes past the last class in the final word are masked off.
    for (genvar gi = 0; gi < AF; gi++) begin : g_mask
        assign lane_mask[gi] = (word_base + (IDX_W+1)'(gi)) < (IDX_W+1)'(FOUT3);
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        load_out   = 1'b0;
        case (state_reg)
            IDLE:  if (start) state_next = SCAN;
            SCAN: begin
                if (rd_valid) begin
                    accept = 1'b1;
                    if (last_word) state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_reg) begin
                    state_next = HOLD;
                    load_out   = 1'b1;
                end
            end
            HOLD:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            flush_cnt_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            run_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= (state_reg == FLUSH);
            s1_valid_reg  <= accept;
            if (accept && !last_word) word_reg <= word_reg + 1'b1;
            if (s1_valid_reg) run_valid_reg <= 1'b1;
            if (state_reg == IDLE && start) begin
                word_reg      <= '0;
                run_valid_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < BATCH; gi++) begin : g_batch
        argmax_lane_reduce u_reduce (
            .lanes     (rd_data[gi*AF*DATA_WIDTH +: AF*DATA_WIDTH]),
            .lane_mask (lane_mask),
            .max_val   (red_val[gi]),
            .max_lane  (red_lane[gi])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_val_reg[gi]    <= '0;
                s1_idx_reg[gi]    <= '0;
                run_val_reg[gi]   <= '0;
                run_idx_reg[gi]   <= '0;
                top_score_reg[gi] <= '0;
                top_idx_reg[gi]   <= '0;
            end else begin
                if (accept) begin
                    s1_val_reg[gi] <= red_val[gi];
                    s1_idx_reg[gi] <= word_base[IDX_W-1:0] + cls_idx_t'(red_lane[gi]);
                end
                // later words carry higher classes, so strict > keeps the lower index
                if (s1_valid_reg && (!run_valid_reg || s1_val_reg[gi] > run_val_reg[gi])) begin
                    run_val_reg[gi] <= s1_val_reg[gi];
                    run_idx_reg[gi] <= s1_idx_reg[gi];
                end
                if (load_out) begin
                    top_score_reg[gi] <= run_val_reg[gi];
                    top_idx_reg[gi]   <= run_idx_reg[gi];
                end
            end
        end

        assign top_idx[gi*IDX_W +: IDX_W]             = top_idx_reg[gi];
        assign top_score[gi*DATA_WIDTH +: DATA_WIDTH] = top_score_reg[gi];
    end

endmodule
